// File: rtl/ucsbece154a_dmem_responder_if.sv
// Request/response bus between a requester and the data-memory responder.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface ucsbece154a_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ucsbece154a_dmem_responder.sv
// Single-outstanding data-memory responder.
// Accepts one request in IDLE, performs the access LATENCY edges later, and holds the response until it is consumed.
module ucsbece154a_dmem_responder #(
  parameter int WORDS   = 64,
  parameter int LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  ucsbece154a_dmem_responder_if.slave    bus,
  output logic [1:0]                     dbg_state_o
);

  localparam int          AW      = $clog2(WORDS);
  localparam logic [3:0]  LAT4    = 4'(LATENCY);
  localparam logic [29:0] WORDS_W = 30'(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [31:0] RAM [0:WORDS-1];

  logic          addr_err;
  logic [AW-1:0] word_idx;
  logic          access;
  logic          ram_we;
  logic [31:0]   resp_rdata_d;

  // Misaligned or past-the-end accesses are answered with an error and never touch RAM.
  always_comb begin
    addr_err     = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= WORDS_W);
    word_idx     = addr_q[AW+1:2];
    access       = (state_q == WAIT) && (cnt_q == 4'd1);
    ram_we       = access && we_q && !addr_err;
    resp_rdata_d = 32'd0;
    if (!addr_err && !we_q) begin
      resp_rdata_d = RAM[word_idx];
    end
  end

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      RAM[word_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            cnt_q       <= LAT4;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // The count reaching 1 marks the access edge, so resp_valid rises LATENCY edges after acceptance.
          if (cnt_q == 4'd1) begin
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= addr_err;
            resp_rdata_q <= resp_rdata_d;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          cnt_q        <= 4'd0;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'd0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/ucsbece154a_dmem_responder.md
UCSBECE154A_DMEM_RESPONDER -- requirements
Module: ucsbece154a_dmem_responder

Interface
REQ-001 The block SHALL have parameter WORDS, default 64: number of 32-bit words in the internal RAM (power of two, 16..1024).
REQ-002 The block SHALL have parameter LATENCY, default 2: edges from request acceptance to response-valid (1..15).
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: reset is asynchronous and active-high.
REQ-005 Port req_valid, input, 1: requester presents a transaction.
REQ-006 Port req_ready, output, 1: responder can accept a transaction this cycle.
REQ-007 Port req_we, input, 1: 1 = write, 0 = read.
REQ-008 Port req_addr, input, 32: byte address; word index = req_addr[31:2].
REQ-009 Port req_wdata, input, 32: write data.
REQ-010 Port resp_valid, output, 1: response present.
REQ-011 Port resp_ready, input, 1: requester consumes the response.
REQ-012 Port resp_rdata, output, 32: read data.
REQ-013 Port resp_err, output, 1: transaction was rejected (misaligned or out of range).
REQ-014 Storage SHALL be a reg array named RAM[0:WORDS-1] of 32 bits, reachable hierarchically by benches.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-016 Acceptance SHALL occur on a rising edge in IDLE with req_valid = 1; req_we, req_addr and req_wdata are captured and a 4-bit counter is loaded with LATENCY; next state WAIT.
REQ-017 req_valid in WAIT or RESP SHALL be ignored; no capture, no queueing.
REQ-018 In WAIT the counter SHALL decrement on each edge; on the edge where it equals 1 the access is performed and the state becomes RESP, so resp_valid rises exactly LATENCY edges after the acceptance edge.
REQ-019 Error condition: captured addr[1:0] != 0 or word index >= WORDS; resp_err = 1, resp_rdata = 0, RAM unmodified.
REQ-020 A valid write SHALL update RAM[index] with the captured data on the access edge; the response carries resp_rdata = 0, resp_err = 0.
REQ-021 A valid read SHALL register RAM[index] into resp_rdata on the access edge; resp_err = 0.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready = 1, after which the state is IDLE and all three outputs clear to 0.
REQ-023 No back-to-back overlap: the earliest next acceptance SHALL be the edge after the response handshake edge.
REQ-024 Outside RESP, resp_rdata and resp_err SHALL be 0.

Reset
REQ-025 Asserting reset SHALL immediately (without a clock edge) force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1.
REQ-026 Reset SHALL NOT clear RAM contents.
REQ-027 A transaction in WAIT when reset asserts SHALL be abandoned: a pending write is never performed.
REQ-028 A response in RESP when reset asserts SHALL be dropped without the handshake.
REQ-029 While reset is high, no acceptance SHALL occur. The first acceptance is possible on the first rising edge after deassertion.

Verification (LATENCY=2, WORDS=64)
REQ-030 Scenario 1: write 32'd7 to 0x50 with resp_ready = 1 -> resp_valid is high 2 edges after acceptance, resp_err = 0, and RAM[20] = 7 on the following negedge.
REQ-031 Scenario 2: read 0x50 after Scenario 1 -> resp_rdata = 32'h7, resp_err = 0, req_ready = 0 until the handshake.
REQ-032 Scenario 3: read 0x50 with resp_ready held low for 3 cycles -> resp_valid, resp_rdata = 7 and req_ready = 0 hold for all 3 cycles; IDLE follows the edge where resp_ready = 1.
REQ-033 Scenario 4: write 32'hc to 0x52, then write to 0x100 -> resp_err = 1 for both and RAM[20] remains 7.
REQ-034 Scenario 5: write 32'd7 to 0x54, with reset pulsed in WAIT -> outputs clear asynchronously, RAM[21] is unchanged, and req_ready = 1.
REQ-035 Scenario 6: req_valid held high through a full transaction -> exactly one acceptance per IDLE visit, and the second acceptance occurs on the edge after the handshake.
